// File: rtl/pmc_multi_domain_pkg.sv
// Shared types for the multi-domain power-management controller.
package pmc_multi_domain_pkg;

  // Per-channel sequencer states; encodings are fixed so they can be probed externally.
  typedef enum logic [2:0] {
    StOff   = 3'd0,
    StWait  = 3'd1,
    StWake  = 3'd2,
    StOn    = 3'd3,
    StDrain = 3'd4
  } pmc_state_e;

  // Per-channel trigger mode codes.
  typedef enum logic [1:0] {
    ModeOff  = 2'b00,
    ModeLvl  = 2'b01,
    ModeRise = 2'b10,
    ModeFall = 2'b11
  } pmc_mode_e;

endpackage

// File: rtl/pmc_multi_domain_chan.sv
// One power-domain channel: activity synchroniser, trigger detect, sequencer FSM and counter.
module pmc_multi_domain_chan
  import pmc_multi_domain_pkg::*;
#(
  parameter int unsigned CNTW     = 10,
  parameter int unsigned WAKE_CYC = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            force_on_i,
  input  logic            act_i,
  input  logic [1:0]      mode_i,
  input  logic [CNTW-1:0] hold_i,
  input  logic            grant_i,
  output logic            in_wait_o,
  output logic            in_wake_o,
  output logic            busy_o,
  output logic            pwr_en_o,
  output logic            iso_n_o,
  output logic            ready_o
);

  // The same counter times the ramp in StWake and the idle hold in StOn.
  localparam logic [CNTW-1:0] WakeLoad = CNTW'(WAKE_CYC - 1);

  pmc_mode_e       mode;
  logic [2:0]      sync_d, sync_q;
  logic            act_s, act_d, rise, fall, trig;
  pmc_state_e      state_d, state_q;
  logic [CNTW-1:0] cnt_d, cnt_q;
  logic            pwr_en_d, pwr_en_q;
  logic            iso_n_d, iso_n_q;

  assign mode  = pmc_mode_e'(mode_i);
  assign act_s = sync_q[1];
  assign act_d = sync_q[2];
  assign rise  = act_s & ~act_d;
  assign fall  = ~act_s & act_d;

  // Synchroniser shift: sync_q[0]=s1, sync_q[1]=act_s, sync_q[2]=act_d.
  always_comb begin
    sync_d = {sync_q[1:0], act_i};
  end

  // Trigger selection; force_on overrides any enabled mode.
  always_comb begin
    trig = 1'b0;
    unique case (mode)
      ModeLvl:  trig = act_s;
      ModeRise: trig = rise;
      ModeFall: trig = fall;
      default:  trig = 1'b0;
    endcase
    if (force_on_i && (mode != ModeOff)) begin
      trig = 1'b1;
    end
  end

  // Sequencer next state and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StOff: begin
        if (trig) state_d = StWait;
      end
      StWait: begin
        if (grant_i) begin
          state_d = StWake;
          cnt_d   = WakeLoad;
        end
      end
      StWake: begin
        if (cnt_q == '0) begin
          state_d = StOn;
          cnt_d   = hold_i;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StOn: begin
        if (trig) begin
          cnt_d = hold_i;
        end else if (cnt_q == '0) begin
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // Single isolated-but-powered cycle before the supply is cut.
      StDrain: begin
        state_d = trig ? StWait : StOff;
      end
      default: begin
        state_d = StOff;
        cnt_d   = '0;
      end
    endcase
    // Disabling a channel drops it immediately, whatever it was doing.
    if (mode == ModeOff) begin
      state_d = StOff;
      cnt_d   = '0;
    end
  end

  // Outputs registered from the next state so the switch controls never glitch.
  always_comb begin
    pwr_en_d = (state_d == StWake) || (state_d == StOn) || (state_d == StDrain);
    iso_n_d  = (state_d == StOn);
  end

  // State, counter, synchroniser and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      state_q  <= StOff;
      cnt_q    <= '0;
      pwr_en_q <= 1'b0;
      iso_n_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pwr_en_q <= pwr_en_d;
      iso_n_q  <= iso_n_d;
    end
  end

  assign in_wait_o = (state_q == StWait);
  assign in_wake_o = (state_q == StWake);
  assign busy_o    = (state_q != StOff);
  assign pwr_en_o  = pwr_en_q;
  assign iso_n_o   = iso_n_q;
  assign ready_o   = iso_n_q;

endmodule

// File: rtl/pmc_multi_domain.sv
// Multi-domain power-management controller: NCH channels with a one-at-a-time wake arbiter.
module pmc_multi_domain
  import pmc_multi_domain_pkg::*;
#(
  parameter int unsigned NCH      = 5,
  parameter int unsigned CNTW     = 10,
  parameter int unsigned WAKE_CYC = 4
) (
  input  logic                clk,
  input  logic                res,
  input  logic                force_on,
  input  logic [NCH-1:0]      act,
  input  logic [2*NCH-1:0]    mode,
  input  logic [CNTW*NCH-1:0] hold,
  output logic [NCH-1:0]      pwr_en,
  output logic [NCH-1:0]      iso_n,
  output logic [NCH-1:0]      ready,
  output logic                busy
);

  logic [NCH-1:0] in_wait, in_wake, grant, chan_busy;
  logic           taken;

  // Fixed-priority wake arbiter: lowest waiting index, only while nobody is ramping.
  always_comb begin
    grant = '0;
    taken = |in_wake;
    for (int i = 0; i < NCH; i++) begin
      if (in_wait[i] && !taken) begin
        grant[i] = 1'b1;
        taken    = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    pmc_multi_domain_chan #(
      .CNTW     (CNTW),
      .WAKE_CYC (WAKE_CYC)
    ) u_chan (
      .clk_i      (clk),
      .rst_ni     (res),
      .force_on_i (force_on),
      .act_i      (act[i]),
      .mode_i     (mode[2*i +: 2]),
      .hold_i     (hold[CNTW*i +: CNTW]),
      .grant_i    (grant[i]),
      .in_wait_o  (in_wait[i]),
      .in_wake_o  (in_wake[i]),
      .busy_o     (chan_busy[i]),
      .pwr_en_o   (pwr_en[i]),
      .iso_n_o    (iso_n[i]),
      .ready_o    (ready[i])
    );
  end

  assign busy = |chan_busy;

endmodule
